// File: rtl/pwm_avalon_multi_if.sv
// Avalon-MM slave bus bundle for pwm_avalon_multi (32-bit data, 4-bit word address).
interface pwm_avalon_multi_if;
    logic        chipselect;
    logic [3:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (
        output chipselect,
        output address,
        output write,
        output writedata,
        output read,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  address,
        input  write,
        input  writedata,
        input  read,
        output readdata
    );
endinterface

// File: rtl/pwm_avalon_multi.sv
// Multi-channel PWM peripheral on an Avalon-MM slave port.
// Shared prescaler and period, double-buffered period/duty loaded on wrap,
// active duties exported on `value`.
// Optional period interrupt (STATUS register and `irq` port) with PWM_MULTI_IRQ_EN.
module pwm_avalon_multi #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    pwm_avalon_multi_if.slave         bus,
    output logic [CHANNELS-1:0]       pwmout,
    output logic [CHANNELS*WIDTH-1:0] value
`ifdef PWM_MULTI_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int unsigned PRE_W     = 16;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DUTY_BASE = 4;

    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 4'd2;
`ifdef PWM_MULTI_IRQ_EN
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 4'd3;
`endif

    // Control / configuration registers
    logic                ctrl_run_q,   ctrl_run_d;
    logic [CHANNELS-1:0] ctrl_en_q,    ctrl_en_d;
    logic [PRE_W-1:0]    prescale_q,   prescale_d;
    logic [WIDTH-1:0]    period_sh_q,  period_sh_d;
    logic [WIDTH-1:0]    period_act_q, period_act_d;
    logic [WIDTH-1:0]    duty_sh_q  [CHANNELS];
    logic [WIDTH-1:0]    duty_sh_d  [CHANNELS];
    logic [WIDTH-1:0]    duty_act_q [CHANNELS];
    logic [WIDTH-1:0]    duty_act_d [CHANNELS];

    // Counters
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]    cnt_q,     cnt_d;

    // Registered outputs
    logic [CHANNELS-1:0]       pwmout_q,   pwmout_d;
    logic [CHANNELS*WIDTH-1:0] value_q,    value_d;
    logic [DATA_W-1:0]         readdata_q, readdata_d;

`ifdef PWM_MULTI_IRQ_EN
    logic wrap_q,   wrap_d;
    logic irq_en_q, irq_en_d;
    logic irq_q,    irq_d;
`endif

    logic              wr_c;
    logic              rd_c;
    logic              tick_c;
    logic              wrap_tick_c;
    logic              load_c;
    logic [DATA_W-1:0] rd_data_c;

    assign wr_c = bus.chipselect & bus.write;
    assign rd_c = bus.chipselect & bus.read;

    // Prescaler tick and period wrap, only while running
    assign tick_c      = ctrl_run_q && (pre_cnt_q == prescale_q);
    assign wrap_tick_c = tick_c && (cnt_q == period_act_q);
    // Actives follow shadows while stopped, otherwise only at a wrap
    assign load_c      = !ctrl_run_q || wrap_tick_c;

    // Register-file writes into control and shadow registers
    always_comb begin
        ctrl_run_d  = ctrl_run_q;
        ctrl_en_d   = ctrl_en_q;
        prescale_d  = prescale_q;
        period_sh_d = period_sh_q;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            duty_sh_d[k] = duty_sh_q[k];
        end
        if (wr_c) begin
            case (bus.address)
                ADDR_CTRL: begin
                    ctrl_run_d = bus.writedata[31];
                    ctrl_en_d  = bus.writedata[CHANNELS-1:0];
                end
                ADDR_PRESCALE: prescale_d  = bus.writedata[PRE_W-1:0];
                ADDR_PERIOD:   period_sh_d = bus.writedata[WIDTH-1:0];
                default: ;
            endcase
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                if (bus.address == ADDR_W'(DUTY_BASE + k)) begin
                    duty_sh_d[k] = bus.writedata[WIDTH-1:0];
                end
            end
        end
    end

    // Prescaler, main counter and active-register loading
    always_comb begin
        pre_cnt_d    = pre_cnt_q;
        cnt_d        = cnt_q;
        period_act_d = period_act_q;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            duty_act_d[k] = duty_act_q[k];
        end

        if (!ctrl_run_q) begin
            pre_cnt_d = '0;
            cnt_d     = '0;
        end else if (tick_c) begin
            pre_cnt_d = '0;
            cnt_d     = wrap_tick_c ? '0 : cnt_q + WIDTH'(1);
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end

        // Shadow_q is the pre-write value, so a same-cycle write waits one more wrap
        if (load_c) begin
            period_act_d = period_sh_q;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                duty_act_d[k] = duty_sh_q[k];
            end
        end
    end

    // PWM compare and active-duty export
    always_comb begin
        pwmout_d = '0;
        value_d  = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            pwmout_d[k]              = ctrl_run_q & ctrl_en_q[k] & (cnt_q < duty_act_q[k]);
            value_d[k*WIDTH +: WIDTH] = duty_act_q[k];
        end
    end

    // Readback mux: shadow values, unused addresses and bits read 0
    always_comb begin
        rd_data_c = '0;
        case (bus.address)
            ADDR_CTRL:     rd_data_c = {ctrl_run_q, 31'(ctrl_en_q)};
            ADDR_PRESCALE: rd_data_c = DATA_W'(prescale_q);
            ADDR_PERIOD:   rd_data_c = DATA_W'(period_sh_q);
`ifdef PWM_MULTI_IRQ_EN
            ADDR_STATUS:   rd_data_c = DATA_W'({irq_en_q, wrap_q});
`endif
            default: ;
        endcase
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (bus.address == ADDR_W'(DUTY_BASE + k)) begin
                rd_data_c = DATA_W'(duty_sh_q[k]);
            end
        end
        readdata_d = rd_c ? rd_data_c : readdata_q;
    end

`ifdef PWM_MULTI_IRQ_EN
    // Wrap flag: set by each wrap tick, W1C, set wins over clear
    always_comb begin
        wrap_d   = wrap_q;
        irq_en_d = irq_en_q;
        if (wr_c && (bus.address == ADDR_STATUS)) begin
            irq_en_d = bus.writedata[1];
            if (bus.writedata[0]) begin
                wrap_d = 1'b0;
            end
        end
        if (wrap_tick_c) begin
            wrap_d = 1'b1;
        end
        irq_d = wrap_q & irq_en_q;
    end
`endif

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_run_q   <= 1'b0;
            ctrl_en_q    <= '0;
            prescale_q   <= '0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                duty_sh_q[k]  <= '0;
                duty_act_q[k] <= '0;
            end
            pre_cnt_q    <= '0;
            cnt_q        <= '0;
            pwmout_q     <= '0;
            value_q      <= '0;
            readdata_q   <= '0;
`ifdef PWM_MULTI_IRQ_EN
            wrap_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            irq_q        <= 1'b0;
`endif
        end else begin
            ctrl_run_q   <= ctrl_run_d;
            ctrl_en_q    <= ctrl_en_d;
            prescale_q   <= prescale_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                duty_sh_q[k]  <= duty_sh_d[k];
                duty_act_q[k] <= duty_act_d[k];
            end
            pre_cnt_q    <= pre_cnt_d;
            cnt_q        <= cnt_d;
            pwmout_q     <= pwmout_d;
            value_q      <= value_d;
            readdata_q   <= readdata_d;
`ifdef PWM_MULTI_IRQ_EN
            wrap_q       <= wrap_d;
            irq_en_q     <= irq_en_d;
            irq_q        <= irq_d;
`endif
        end
    end

    assign pwmout       = pwmout_q;
    assign value        = value_q;
    assign bus.readdata = readdata_q;
`ifdef PWM_MULTI_IRQ_EN
    assign irq          = irq_q;
`endif

endmodule

// File: tb/tb_pwm_avalon_multi.sv
// Scoreboard bench for pwm_avalon_multi (CHANNELS=4, WIDTH=8).
// Stimulus pushes expected read data and per-cycle output expectations;
// a monitor pops and compares one cycle after each edge.
module tb_pwm_avalon_multi;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 8;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic [CH-1:0]     pwmout;
    logic [CH*W-1:0]   value;
`ifdef PWM_MULTI_IRQ_EN
    logic              irq;
`endif

    pwm_avalon_multi_if bus ();

    pwm_avalon_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .pwmout  (pwmout),
        .value   (value)
`ifdef PWM_MULTI_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
    } rd_exp_t;

    typedef struct {
        string       name;
        logic [CH-1:0] pwm;
        logic        val_chk;
        logic [31:0] val;
    } wv_exp_t;

    rd_exp_t rd_q[$];
    wv_exp_t wv_q[$];
    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Duty layout {d3=5, d2=10, d1=0, d0}
    function automatic logic [31:0] mkval(input logic [7:0] d0);
        return {8'd5, 8'd10, 8'd0, d0};
    endfunction

    // Monitor: read data one cycle after a read, outputs every cycle with expectations queued
    initial begin : monitor
        rd_exp_t r;
        wv_exp_t w;
        logic    fired;
        forever begin
            @(posedge clk);
            fired = bus.chipselect && bus.read && reset_n;
            #1;
            if (fired) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %h expected none", bus.readdata);
                end else begin
                    r = rd_q.pop_front();
                    check(r.name, bus.readdata, r.data);
                end
            end
            if (wv_q.size() != 0) begin
                w = wv_q.pop_front();
                check({w.name, "_pwm"}, 32'(pwmout), 32'(w.pwm));
                if (w.val_chk) check({w.name, "_val"}, 32'(value), w.val);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        rd_q.push_back('{name, exp});
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    task automatic push_wv(input string name, input logic [CH-1:0] pwm, input logic vc, input logic [31:0] v);
        wv_q.push_back('{name, pwm, vc, v});
    endtask

    task automatic drain();
        int n = 0;
        while ((wv_q.size() != 0 || rd_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", wv_q.size() + rd_q.size());
            wv_q.delete();
            rd_q.delete();
        end
    endtask

    initial begin : stim
        int c;
        int d;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pwmout", 32'(pwmout), 32'd0);
        check("rst_value", value, 32'd0);
        check("rst_readdata", bus.readdata, 32'd0);
`ifdef PWM_MULTI_IRQ_EN
        check("rst_irq", 32'(irq), 32'd0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 9; a++) bus_read(4'(a), 32'd0, $sformatf("rst_rd%0d", a));

        // Configuration and readback
        bus_write(4'd1, 32'd0);
        bus_write(4'd2, 32'hFFFF_FF09);
        bus_write(4'd4, 32'd3);
        bus_write(4'd5, 32'd0);
        bus_write(4'd6, 32'd10);
        bus_write(4'd7, 32'd5);
        bus_write(4'd8, 32'h1234_5678);
        bus_read(4'd2, 32'd9, "rd_period");
        bus_read(4'd6, 32'd10, "rd_duty2");
        bus_read(4'd8, 32'd0, "rd_unused");
`ifndef PWM_MULTI_IRQ_EN
        bus_write(4'd3, 32'd3);
        bus_read(4'd3, 32'd0, "rd_status_absent");
`endif

        // Basic PWM: N=9, duty0=3, ch1 const low, ch2 const high, ch3 disabled
        bus_write(4'd0, 32'h8000_0007);
        for (int i = 0; i < 20; i++)
            push_wv("basic", {1'b0, 1'b1, 1'b0, 1'((i % 10) < 3)}, 1'b1, mkval(8'd3));
        drain();

        // Shadowing: duty0=7 mid-period, applies after the wrap
        bus_write(4'd4, 32'd7);
        for (int k = 23; k <= 41; k++) begin
            c = (k - 2) % 10;
            d = (k <= 31) ? 3 : 7;
            push_wv("shadow", {1'b0, 1'b1, 1'b0, 1'(c < d)}, 1'b1, mkval(8'(d)));
        end
        drain();

        // Write landing on a wrap tick: old shadow loads, new one a period later
        repeat (9) @(negedge clk);
        bus_write(4'd4, 32'd2);
        for (int k = 52; k <= 71; k++) begin
            c = (k - 2) % 10;
            d = (k <= 61) ? 7 : 2;
            push_wv("wrapwr", {1'b0, 1'b1, 1'b0, 1'(c < d)}, 1'b1, mkval(8'(d)));
        end
        drain();

        // Stop: outputs low, then restart from count 0
        bus_write(4'd0, 32'h0000_0007);
        for (int k = 0; k < 5; k++) push_wv("stop", 4'b0000, 1'b1, mkval(8'd2));
        drain();
        bus_write(4'd0, 32'h8000_0007);
        for (int k = 0; k < 10; k++) push_wv("start", {1'b0, 1'b1, 1'b0, 1'(k < 2)}, 1'b0, 32'd0);
        drain();

        // Enable bit change acts without waiting for a wrap
        bus_write(4'd0, 32'h8000_0006);
        for (int k = 0; k < 4; k++) push_wv("endis", 4'b0100, 1'b0, 32'd0);
        drain();

        // Prescaler P=2: 30-clock period, 6-clock high time
        bus_write(4'd0, 32'd0);
        bus_write(4'd1, 32'd2);
        bus_read(4'd0, 32'd0, "rd_ctrl_off");
        bus_write(4'd0, 32'h8000_0001);
        for (int j = 1; j <= 60; j++) push_wv("presc", {3'b000, 1'(((j - 1) % 30) < 6)}, 1'b1, mkval(8'd2));
        drain();

        // N=255 wraps to 0: one high clock every 256
        bus_write(4'd0, 32'd0);
        bus_write(4'd1, 32'd0);
        bus_write(4'd2, 32'd255);
        bus_write(4'd4, 32'd1);
        bus_write(4'd0, 32'h8000_0001);
        for (int j = 1; j <= 258; j++) push_wv("n255", {3'b000, 1'(((j - 1) % 256) < 1)}, 1'b1, mkval(8'd1));
        drain();

        // Asynchronous reset while output is high
        bus_write(4'd0, 32'd0);
        bus_write(4'd2, 32'd9);
        bus_write(4'd4, 32'd5);
        bus_read(4'd2, 32'd9, "rd_period9");
        bus_write(4'd0, 32'h8000_0001);
        for (int j = 1; j <= 2; j++) push_wv("prerst", 4'b0001, 1'b1, mkval(8'd5));
        drain();
        #2 reset_n = 1'b0;
        #1;
        check("arst_pwmout", 32'(pwmout), 32'd0);
        check("arst_value", value, 32'd0);
        check("arst_readdata", bus.readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 8; a++) bus_read(4'(a), 32'd0, $sformatf("arst_rd%0d", a));

`ifdef PWM_MULTI_IRQ_EN
        // Period interrupt and set-wins-over-clear
        bus_write(4'd2, 32'd9);
        bus_write(4'd3, 32'd3);
        bus_write(4'd0, 32'h8000_0000);
        repeat (10) @(negedge clk);
        check("irq_before", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_rise", 32'(irq), 32'd1);
        repeat (8) @(negedge clk);
        bus_write(4'd3, 32'd3);
        bus_read(4'd3, 32'd3, "status_setwins");
        bus_write(4'd3, 32'd3);
        bus_read(4'd3, 32'd2, "status_cleared");
        check("irq_fall", 32'(irq), 32'd0);
`endif

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
